arima_result_logger: RTL

ARIMA_RESULT_LOGGER -- requirements
Module: arima_result_logger

---
 rtl/arima_result_logger_if.sv | 24 ++
 rtl/arima_result_logger.sv | 108 ++++++++++
 2 files changed

// File: rtl/arima_result_logger_if.sv
// Result handshake and readout channel between an ARIMA detector/reader and the result logger.
interface arima_result_logger_if #(
    parameter int TS_W = 16
);
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         prediction;
    logic                label;
    logic                overflow;
    logic [31:0]         time_step;
    logic                rd_en;
    logic                rd_valid;
    logic [34+TS_W-1:0]  rd_data;

    modport master (
        output res_valid, prediction, label, overflow, time_step, rd_en,
        input  res_ready, rd_valid, rd_data
    );

    modport slave (
        input  res_valid, prediction, label, overflow, time_step, rd_en,
        output res_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/arima_result_logger.sv
// Circular buffer logging ARIMA detector results under an IDLE/LOG/STOPPED control FSM,
// with a registered single-record readout port and anomaly/drop bookkeeping.
module arima_result_logger #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    arima_result_logger_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              anomaly_cnt,
    output logic                     dropped,
    output logic [3:0]               leds
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 34 + TS_W;

    typedef enum logic [1:0] {IDLE, LOG, STOPPED} state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [RW-1:0]   mem [DEPTH];
    logic [RW-1:0]   record;
    logic            full;
    logic            empty;
    logic            wr_fire;
    logic            rd_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)          state_next = LOG;
                LOG:     if (stop)           state_next = STOPPED;
                STOPPED: if (start && !stop) state_next = LOG;
                default:                     state_next = IDLE;
            endcase
        end
    end

    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign bus.res_ready = (state == LOG) && !full && !clear;
    assign wr_fire       = bus.res_valid && bus.res_ready;
    // A pop requested in the same cycle as clear is discarded along with the buffer.
    assign rd_fire       = bus.rd_en && !empty && !clear;
    assign record        = {bus.time_step[TS_W-1:0], bus.overflow, bus.label, bus.prediction};
    assign leds          = {state == LOG, full, empty, dropped};

    generate
        if (TS_W < 32) begin : g_ts_unused
            logic unused_ts_high;
            assign unused_ts_high = ^bus.time_step[31:TS_W];
        end
    endgenerate

    // Unreset storage so it maps onto a simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= record;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            anomaly_cnt  <= '0;
            dropped      <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            anomaly_cnt  <= '0;
            dropped      <= 1'b0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_fire;
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) begin
                bus.rd_data <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_fire && bus.label && (anomaly_cnt != 16'hFFFF))
                anomaly_cnt <= anomaly_cnt + 1'b1;
            if ((state == LOG) && bus.res_valid && full)
                dropped <= 1'b1;
        end
    end
endmodule
